// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: state encoding and default widths for the dcache/icache memory arbiter.
package mem_arb_pkg;
  localparam int ADDR_W_DEF = 32;
  localparam int LINE_W_DEF = 256;
  typedef enum logic [1:0] {
    STATE_IDLE   = 2'd0,
    STATE_GRANT0 = 2'd1,
    STATE_GRANT1 = 2'd2,
    STATE_GAP    = 2'd3
  } state_e;
endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: two-way grant picker; fixed priority to port 0, round-robin when MEM_ARB_RR_EN is defined.
module mem_arb_pick (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt
);
`ifdef MEM_ARB_RR_EN
  assign gnt = (req[0] & req[1]) ? ~last : req[1];
`else
  // with no request the result is unused; it echoes the pointer
  assign gnt = req[0] ? 1'b0 : (req[1] | last);
`endif
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one line-wide memory port between dcache (port 0) and icache (port 1).
// Grant held until mem ack, then a one-cycle gap; MEM_ARB_RR_EN selects round-robin arbitration.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LINE_W = LINE_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              c0_enable_i,
  input  logic              c0_write_i,
  input  logic [ADDR_W-1:0] c0_addr_i,
  input  logic [LINE_W-1:0] c0_data_i,
  output logic [LINE_W-1:0] c0_data_o,
  output logic              c0_ack_o,
  input  logic              c1_enable_i,
  input  logic              c1_write_i,
  input  logic [ADDR_W-1:0] c1_addr_i,
  input  logic [LINE_W-1:0] c1_data_i,
  output logic [LINE_W-1:0] c1_data_o,
  output logic              c1_ack_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic              busy_o
);
  state_e state;
  logic   last;
  logic   pick;
  mem_arb_pick u_pick (
    .req ({c1_enable_i, c0_enable_i}),
    .last(last),
    .gnt (pick)
  );
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= STATE_IDLE;
      last         <= 1'b1;
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_addr_o   <= '0;
      mem_data_o   <= '0;
    end else begin
      case (state)
        STATE_IDLE: if (c0_enable_i | c1_enable_i) begin
          state        <= pick ? STATE_GRANT1 : STATE_GRANT0;
          mem_enable_o <= 1'b1;
          mem_write_o  <= pick ? c1_write_i : c0_write_i;
          mem_addr_o   <= pick ? c1_addr_i : c0_addr_i;
          mem_data_o   <= pick ? c1_data_i : c0_data_i;
        end
        STATE_GRANT0, STATE_GRANT1: if (mem_ack_i) begin
          state        <= STATE_GAP;
          mem_enable_o <= 1'b0;
          mem_write_o  <= 1'b0;
          last         <= (state == STATE_GRANT1);
        end
        STATE_GAP: state <= STATE_IDLE;
        default: state <= STATE_IDLE;
      endcase
    end
  end
  assign c0_ack_o  = (state == STATE_GRANT0) & mem_ack_i;
  assign c1_ack_o  = (state == STATE_GRANT1) & mem_ack_i;
  assign c0_data_o = c0_ack_o ? mem_data_i : '0;
  assign c1_data_o = c1_ack_o ? mem_data_i : '0;
  assign busy_o    = (state != STATE_IDLE);
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of grant, gap, reset abandonment and stray acks for mem_arbiter.
module tb_mem_arbiter;
  logic         clk = 1'b0;
  logic         rst_i = 1'b1;
  logic         c0_enable_i = 1'b0, c0_write_i = 1'b0;
  logic [31:0]  c0_addr_i = '0;
  logic [255:0] c0_data_i = '0, c0_data_o;
  logic         c0_ack_o;
  logic         c1_enable_i = 1'b0, c1_write_i = 1'b0;
  logic [31:0]  c1_addr_i = '0;
  logic [255:0] c1_data_i = '0, c1_data_o;
  logic         c1_ack_o;
  logic         mem_enable_o, mem_write_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic [255:0] mem_data_i = '0;
  logic         mem_ack_i = 1'b0;
  logic         busy_o;
  int           n_checks = 0;
  int           n_errors = 0;
`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  localparam logic [255:0] PAT_A5 = {32{8'hA5}};
  localparam logic [255:0] PAT_WB = {8{32'hDEAD_BEEF}};
  mem_arbiter dut (
    .clk_i(clk), .rst_i(rst_i),
    .c0_enable_i(c0_enable_i), .c0_write_i(c0_write_i), .c0_addr_i(c0_addr_i),
    .c0_data_i(c0_data_i), .c0_data_o(c0_data_o), .c0_ack_o(c0_ack_o),
    .c1_enable_i(c1_enable_i), .c1_write_i(c1_write_i), .c1_addr_i(c1_addr_i),
    .c1_data_i(c1_data_i), .c1_data_o(c1_data_o), .c1_ack_o(c1_ack_o),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
    .busy_o(busy_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // runs one transaction starting from an IDLE cycle with requests already driven
  task automatic xact(input string tag, input logic port, input logic [31:0] addr,
                      input logic wr, input logic [255:0] wdata,
                      input logic [255:0] rdata, input int lat);
    tick();
    chk({tag, "_en"}, mem_enable_o, 1);
    chk({tag, "_addr"}, mem_addr_o, addr);
    chk({tag, "_wr"}, mem_write_o, wr);
    if (wr) chk({tag, "_wdata"}, mem_data_o, wdata);
    repeat (lat) tick();
    chk({tag, "_hold"}, {mem_enable_o, busy_o}, 2'b11);
    mem_data_i = rdata;
    mem_ack_i  = 1'b1;
    #1;
    chk({tag, "_ack"}, {c1_ack_o, c0_ack_o}, port ? 2'b10 : 2'b01);
    chk({tag, "_d0"}, c0_data_o, port ? '0 : rdata);
    chk({tag, "_d1"}, c1_data_o, port ? rdata : '0);
    tick();
    mem_ack_i  = 1'b0;
    mem_data_i = '0;
    #1;
    chk({tag, "_gap"}, {mem_enable_o, mem_write_o, c1_ack_o, c0_ack_o, busy_o}, 5'b00001);
    tick();
    chk({tag, "_idle"}, {mem_enable_o, busy_o}, 2'b00);
  endtask
  initial begin
    tick();
    tick();
    chk("rst_out", {mem_enable_o, mem_write_o, c0_ack_o, c1_ack_o, busy_o}, 5'b0);
    chk("rst_addr", mem_addr_o, 0);
    rst_i = 1'b0;
    // single dcache read
    c0_enable_i = 1'b1; c0_addr_i = 32'h0000_0420;
    xact("rd0", 1'b0, 32'h420, 1'b0, '0, PAT_A5, 9);
    c0_enable_i = 1'b0;
    tick();
    // write-back then refill, enable held throughout
    c0_enable_i = 1'b1; c0_write_i = 1'b1; c0_addr_i = 32'h800; c0_data_i = PAT_WB;
    xact("wb", 1'b0, 32'h800, 1'b1, PAT_WB, '0, 2);
    c0_write_i = 1'b0; c0_addr_i = 32'h420; c0_data_i = '0;
    xact("refill", 1'b0, 32'h420, 1'b0, '0, PAT_A5, 3);
    c0_enable_i = 1'b0;
    // simultaneous requests from a fresh pointer
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    c0_enable_i = 1'b1; c0_addr_i = 32'h1000;
    c1_enable_i = 1'b1; c1_addr_i = 32'h2000;
    xact("both1", 1'b0, 32'h1000, 1'b0, '0, 256'h11, 1);
    xact("both2", RR, RR ? 32'h2000 : 32'h1000, 1'b0, '0, 256'h22, 1);
    xact("both3", 1'b0, 32'h1000, 1'b0, '0, 256'h33, 1);
    c0_enable_i = 1'b0;
    xact("c1only", 1'b1, 32'h2000, 1'b0, '0, 256'h44, 1);
    // reset during GRANT1 then a stray ack
    tick();
    chk("pre_rst_grant", {mem_enable_o, mem_addr_o}, {1'b1, 32'h2000});
    rst_i = 1'b1; c1_enable_i = 1'b0;
    tick();
    rst_i = 1'b0;
    chk("rst_mid", {mem_enable_o, mem_write_o, busy_o, c1_ack_o}, 4'b0);
    chk("rst_mid_addr", mem_addr_o, 0);
    tick();
    mem_ack_i = 1'b1; mem_data_i = PAT_A5;
    #1;
    chk("stray_ack", {c1_ack_o, c0_ack_o}, 2'b00);
    chk("stray_data", c1_data_o, 0);
    tick();
    mem_ack_i = 1'b0; mem_data_i = '0;
    chk("stray_idle", {mem_enable_o, busy_o}, 2'b00);
    // icache drops enable mid-grant
    c1_enable_i = 1'b1; c1_addr_i = 32'h3040;
    tick();
    chk("drop_grant", {mem_enable_o, mem_addr_o}, {1'b1, 32'h3040});
    c1_enable_i = 1'b0;
    repeat (3) tick();
    chk("drop_hold", mem_enable_o, 1);
    mem_ack_i = 1'b1; mem_data_i = PAT_WB;
    #1;
    chk("drop_ack", {c1_ack_o, c0_ack_o}, 2'b10);
    chk("drop_data", c1_data_o, PAT_WB);
    tick();
    mem_ack_i = 1'b0; mem_data_i = '0;
    #1;
    chk("drop_once", {c1_ack_o, mem_enable_o, busy_o}, 3'b001);
    tick();
    tick();
    chk("drop_no_reserve", {mem_enable_o, busy_o}, 2'b00);
    // ack in IDLE with no requests
    mem_ack_i = 1'b1; mem_data_i = PAT_A5;
    #1;
    chk("idle_ack", {c1_ack_o, c0_ack_o, busy_o}, 3'b000);
    chk("idle_data", c0_data_o, 0);
    tick();
    mem_ack_i = 1'b0;
    chk("idle_after", {mem_enable_o, busy_o}, 2'b00);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one off-chip data memory port (256-bit line, enable/ack handshake) between two cache clients: port 0 = dcache, port 1 = icache.
- Sits between the cache controllers and data memory.
- Holds a grant for a full transaction until the memory acks, then inserts a one-cycle bus gap.
- Registers all memory-side request signals at grant.

Parameters:
- ADDR_W, 32, byte address width.
- LINE_W, 256, line data width.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset. Synchronous, active-high.
- c0_enable_i  in  1  dcache request. Held high until c0_ack_o.
- c0_write_i  in  1  dcache request is a write-back.
- c0_addr_i  in  ADDR_W  dcache line address (bits [4:0] = 0).
- c0_data_i  in  LINE_W  dcache write data.
- c0_data_o  out  LINE_W  read data to dcache.
- c0_ack_o  out  1  dcache transaction done (1-cycle pulse).
- c1_enable_i, c1_write_i, c1_addr_i, c1_data_i, c1_data_o, c1_ack_o: same as port 0, for the icache.
- mem_enable_o  out  1  memory request.
- mem_write_o  out  1  memory write.
- mem_addr_o  out  ADDR_W  memory address.
- mem_data_o  out  LINE_W  memory write data.
- mem_data_i  in  LINE_W  memory read data.
- mem_ack_i  in  1  memory done (1-cycle pulse).
- busy_o  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst_i high at a clock edge):
  - state = IDLE, last-grant pointer = 1.
  - mem_enable_o = 0, mem_write_o = 0, mem_addr_o = 0, mem_data_o = 0.
  - c0_ack_o = c1_ack_o = 0, busy_o = 0.
  - Reset mid-transaction abandons it; a later mem_ack_i is ignored while in IDLE.
- States: IDLE, GRANT0, GRANT1, GAP.
- IDLE:
  - Requests are sampled each cycle.
  - If any cX_enable_i is high, the winner is chosen (see arbitration). At that edge the winner's write/addr/data are latched into the mem_* outputs, mem_enable_o <= 1, and the state moves to GRANTx.
  - Latency: request present at edge N gives mem_enable_o = 1 from cycle N+1.
- GRANTx:
  - mem_* outputs stay frozen. Client inputs are not re-sampled.
  - On mem_ack_i:
    - cX_ack_o = 1 combinationally in the same cycle.
    - cX_data_o = mem_data_i in that cycle.
    - At the edge: mem_enable_o <= 0, mem_write_o <= 0, last-grant pointer <= x, state <= GAP.
  - The non-granted ack is always 0.
  - cX_data_o is 0 whenever the port's ack is low.
- GAP:
  - mem_enable_o = 0 for exactly one cycle. No arbitration. Next state is IDLE.
  - This guarantees memory sees enable drop between back-to-back transactions, e.g. dcache write-back followed by refill with enable held high.
- Arbitration (default build):
  - Fixed priority: port 0 wins whenever c0_enable_i is high.
- Client contract:
  - A client keeps enable/addr/write/data stable until ack.
  - A client may re-assert enable with a new request in the cycle after ack; it is served at the earliest from IDLE, two cycles after ack.
- Boundary cases:
  - Simultaneous requests in IDLE are resolved by the arbitration rule.
  - mem_ack_i in IDLE or GAP is ignored and produces no client ack.
  - A client dropping enable during its grant does not cancel the transaction; its ack is still produced.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin arbitration. On simultaneous requests, grant the port that is not the last-grant pointer. A single requester always wins.
- Undefined: fixed priority to port 0. The last-grant pointer still exists but does not affect arbitration.

Decomposition:
- Package mem_arb_pkg holds:
  - state encoding constants STATE_IDLE = 2'd0, STATE_GRANT0 = 2'd1, STATE_GRANT1 = 2'd2, STATE_GAP = 2'd3.
  - default widths.
- One natural sub-module, mem_arb_pick: a combinational two-way picker (request bits + last-grant pointer -> grant bit), containing the MEM_ARB_RR_EN selection.

Test Plan:
- Only c0 requests, read, addr 0x0000_0420. Expect mem_enable_o = 1 and mem_addr_o = 0x420 one cycle later. Memory acks after 10 cycles with data 0xA5…A5. Expect c0_ack_o pulse with that data, then one GAP cycle with mem_enable_o = 0.
- c0 write-back to 0x800 held continuously into refill read of 0x420. Expect two memory transactions separated by one enable-low cycle, in order write then read, each with a single c0_ack_o.
- c0 and c1 request in the same cycle, both held:
  - Fixed build: c0, c1, c0, c1 only if c0 drops between requests, else c0 repeatedly.
  - MEM_ARB_RR_EN build: grants alternate c0, c1, c0.
- rst_i asserted during GRANT1 before ack. Expect IDLE next cycle, all outputs 0. A stray mem_ack_i two cycles later produces no c1_ack_o.
- c1 drops enable mid-grant. Expect the transaction to complete and c1_ack_o to pulse once.
- mem_ack_i pulsed while in IDLE with no requests. Expect no ack, no state change, busy_o = 0.
